// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: operation codes and FSM states.
package shift_sequencer_pkg;

    localparam int AMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_RSV = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sequencer_stage.sv
// Fixed-amount combinational shifter: left, logical right or arithmetic right.
import shift_sequencer_pkg::*;

module shift_stage #(
    parameter int WIDTH = 32,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] d,
    input  op_e              op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d >> AMT;
        case (op)
            OP_SLL:  q = d << AMT;
            OP_SRA:  q = $signed(d) >>> AMT;
            default: q = d >> AMT;  // reserved encoding behaves as SRL
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable shift: one coarse or 1-bit stage applied per cycle
// until the latched amount is consumed; start/busy/done handshake.
import shift_sequencer_pkg::*;

module shift_sequencer #(
    parameter int WIDTH    = 32,
    parameter int BIG_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [AMT_W-1:0] BIG_AMT = AMT_W'(BIG_STEP);

    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] acc, acc_big, acc_one, acc_nxt;
    logic [AMT_W-1:0] rem, rem_nxt;
    logic             use_big;

    shift_stage #(.WIDTH(WIDTH), .AMT(BIG_STEP)) u_big (.d(acc), .op(op_q), .q(acc_big));
    shift_stage #(.WIDTH(WIDTH), .AMT(1))        u_one (.d(acc), .op(op_q), .q(acc_one));

    // rem is nonzero whenever this mux feeds the accumulator, so no underflow
    always_comb begin
        use_big = (rem >= BIG_AMT);
        acc_nxt = use_big ? acc_big : acc_one;
        rem_nxt = rem - (use_big ? BIG_AMT : AMT_W'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            acc   <= '0;
            rem   <= '0;
            op_q  <= OP_SLL;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        acc  <= operand;
                        rem  <= amount;
                        op_q <= op_e'(op);
                        if (amount != '0) begin
                            state <= S_SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    acc <= acc_nxt;
                    rem <= rem_nxt;
                    if (rem_nxt == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign result = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected result and latency queued at
// issue, popped and compared when done appears.
module tb_shift_sequencer;

    localparam int W  = 32;
    localparam int BS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  operand = '0;
    logic [4:0]    amount = '0;
    logic          busy, done;
    logic [W-1:0]  result;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] res;
        int           n;
    } exp_t;
    exp_t sb[$];

    shift_sequencer #(.WIDTH(W), .BIG_STEP(BS)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .operand(operand),
        .amount(amount), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] v,
                                           input int a);
        case (o)
            2'b00:   return v << a;
            2'b11:   return $signed(v) >>> a;
            default: return v >> a;
        endcase
    endfunction

    // Push expectation, then present start for exactly one accepting edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] v, input logic [4:0] a);
        exp_t e;
        e.res = model(o, v, int'(a));
        e.n   = int'(a) / BS + int'(a) % BS;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; operand = v; amount = a;
        @(posedge clk); #1;
        start = 1'b0; op = $urandom; operand = $urandom; amount = $urandom;
    endtask

    // Called #1 after the accepting edge; counts further edges until done.
    task automatic wait_done(output int cycles, output int busy_cnt, output bit timed_out);
        cycles = 0; busy_cnt = 0; timed_out = 1'b0;
        while (!done) begin
            if (busy) busy_cnt++;
            if (cycles >= 60) begin
                timed_out = 1'b1;
                return;
            end
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, result} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    logic [1:0]   t_op  [9] = '{2'b00, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
    logic [W-1:0] t_val [9] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF,
                                32'hDEAD_BEEF, 32'h8000_0000, 32'hF0F0_1234, 32'h1234_5678,
                                32'h7FFF_FFFF};
    logic [4:0]   t_amt [9] = '{5'd13, 5'd31, 5'd31, 5'd0, 5'd0, 5'd1, 5'd7, 5'd4, 5'd30};

    task automatic test_table;
        int cyc, bc;
        bit to;
        exp_t e;
        for (int i = 0; i < 9 + 10; i++) begin
            if (i < 9) issue(t_op[i], t_val[i], t_amt[i]);
            else       issue(2'($urandom), $urandom, 5'($urandom));
            wait_done(cyc, bc, to);
            e = sb.pop_front();
            tests++;
            if (to) begin
                fails++;
                $display("FAIL table_timeout[%0d]: done never seen, want after %0d cycles", i, e.n);
                continue;
            end
            if (result !== e.res) begin
                fails++;
                $display("FAIL table_result[%0d]: got %h want %h", i, result, e.res);
            end
            tests++;
            if (cyc != e.n || bc != e.n) begin
                fails++;
                $display("FAIL table_latency[%0d]: cycles=%0d busy=%0d want %0d", i, cyc, bc, e.n);
            end
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== e.res) begin
                fails++;
                $display("FAIL table_hold[%0d]: done=%b busy=%b result=%h want 0 0 %h",
                         i, done, busy, result, e.res);
            end
        end
    endtask

    task automatic test_ignore_and_back_to_back;
        int cyc, bc;
        bit to;
        exp_t e;
        issue(2'b00, 32'h0000_0001, 5'd13);
        @(negedge clk);
        start = 1'b1; op = 2'b11; operand = 32'hFFFF_0000; amount = 5'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bc, to);
        cyc = cyc + 1;
        bc = bc + 1;
        e = sb.pop_front();
        tests++;
        if (to || result !== e.res || cyc != e.n) begin
            fails++;
            $display("FAIL ignore_start: to=%b result=%h cycles=%0d want %h %0d",
                     to, result, cyc, e.res, e.n);
        end
        if (to) return;
        e.res = 32'h0F00_0000; e.n = 1;
        sb.push_back(e);
        start = 1'b1; op = 2'b01; operand = 32'hF000_0000; amount = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
        end
        wait_done(cyc, bc, to);
        e = sb.pop_front();
        tests++;
        if (to || result !== e.res || cyc != e.n) begin
            fails++;
            $display("FAIL b2b_result: to=%b result=%h cycles=%0d want %h %0d",
                     to, result, cyc, e.res, e.n);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, bc;
        bit to;
        bit saw_done;
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = 2'b00; operand = 32'h1; amount = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({busy, done, result} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        @(negedge clk); reset = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL reset_mid_idle: activity after reset, want idle");
        end
        issue(2'b00, 32'h1, 5'd20);
        wait_done(cyc, bc, to);
        e = sb.pop_front();
        tests++;
        if (to || result !== e.res || cyc != e.n || bc != e.n) begin
            fails++;
            $display("FAIL reset_mid_next: result=%h cycles=%0d busy=%0d want %h %0d",
                     result, cyc, bc, e.res, e.n);
        end
    endtask

    initial begin
        test_reset();
        test_table();
        test_ignore_and_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
